// File: rtl/pb_pkg.sv
// Shared types and elaboration helpers for the push-button debounce bank.
package pb_pkg;

  // Filter state; the debounced level is the state itself.
  typedef enum logic {
    IDLE_RELEASED = 1'b0,
    IDLE_PRESSED  = 1'b1
  } pb_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic bit params_ok(input int channels, input int tick_div,
                                   input int stable_ticks, input int repeat_delay,
                                   input int repeat_rate);
    return (channels >= 1) && (tick_div >= 2) && (stable_ticks >= 1) &&
           (repeat_delay >= 1) && (repeat_rate >= 1);
  endfunction

endpackage

// File: rtl/pb_debounce_cell.sv
// One button channel: 2-flop synchroniser, tick-qualified stability filter,
// registered press/release strobes and optional auto-repeat.
module pb_debounce_cell
  import pb_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb_raw,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release
);

  localparam logic POL = (ACTIVE_LOW != 0);
  localparam int SW = cnt_width(STABLE_TICKS - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

  logic          sync1;
  logic          s;
  pb_state_e     state;
  pb_state_e     state_next;
  logic [SW-1:0] cnt;
  logic [SW-1:0] cnt_next;
  logic          pressed;
  logic          accept;
  logic          rpt_fire;
  logic          press_next;
  logic          release_next;

  assign pressed = (state == IDLE_PRESSED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= 1'b0;
      s          <= 1'b0;
      state      <= IDLE_RELEASED;
      cnt        <= '0;
      pb_press   <= 1'b0;
      pb_release <= 1'b0;
    end else begin
      sync1      <= pb_raw ^ POL;
      s          <= sync1;
      state      <= state_next;
      cnt        <= cnt_next;
      pb_press   <= press_next;
      pb_release <= release_next;
    end
  end

  // Any cycle where the synchronised input agrees with the level restarts qualification.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    if (s == pressed) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt == STABLE_LAST) begin
        accept     = 1'b1;
        cnt_next   = '0;
        state_next = s ? IDLE_PRESSED : IDLE_RELEASED;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pb_level     = pressed;
    press_next   = (accept && (state_next == IDLE_PRESSED)) || rpt_fire;
    release_next = accept && (state_next == IDLE_RELEASED);
  end

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = cnt_width(RMAX - 1);

    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_last;
    logic          rpt_phase;

    // First period is the initial delay, every later one the repeat rate.
    assign rpt_last = rpt_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
    // A release accepted on the same tick wins over the repeat.
    assign rpt_fire = tick && pressed && !accept && (rpt_cnt == rpt_last);

    always_ff @(posedge clk) begin
      if (!rst || !pressed || accept) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (tick) begin
        if (rpt_fire) begin
          rpt_cnt   <= '0;
          rpt_phase <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end

endmodule

// File: rtl/pb_debounce_bank.sv
// Multi-channel push-button conditioner: shared debounce tick generator
// feeding one independent debounce cell per channel.
module pb_debounce_bank
  import pb_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_level,
  output logic [CHANNELS-1:0] pb_press,
  output logic [CHANNELS-1:0] pb_release
);

  localparam int TW = cnt_width(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (!params_ok(CHANNELS, TICK_DIV, STABLE_TICKS, REPEAT_DELAY, REPEAT_RATE)) begin : g_bad_params
    $error("pb_debounce_bank: illegal parameter set");
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pb_debounce_cell #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .pb_raw    (pb_in[i]),
      .pb_level  (pb_level[i]),
      .pb_press  (pb_press[i]),
      .pb_release(pb_release[i])
    );
  end

endmodule
